// File: rtl/stepmotor_seq_master.sv
// Step-pattern sequencer: an Avalon-MM read master that walks a table of
// words in on-chip RAM. Each word drives the motor coils and holds them for
// a per-word dwell time. A sequence runs once or loops until stopped.
module stepmotor_seq_master #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              loop,
    output logic              busy,
    output logic              done,
    output logic [3:0]        coils,
    output logic              step_pulse,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    output logic              avm_write,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata
);

    // S_ARM loads the registered RAM address from the freshly latched base,
    // so the address bus never carries a combinational adder path.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_WAIT,
        S_DWELL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [3:0]        coils_q, coils_d;
    logic              step_q, step_d;
    logic              done_q, done_d;

    logic [ADDR_W:0]   index_inc;
    logic              last_word;
    logic [15:0]       dwell;
    logic              unused_rdata;

    assign index_inc    = {1'b0, index_q} + 1'b1;
    assign last_word    = (index_inc == {1'b0, len_q});
    assign dwell        = avm_readdata[31:16];
    // Only [31:16] and [3:0] carry meaning; the rest of the word is ignored.
    assign unused_rdata = ^avm_readdata;

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            index_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            coils_q <= 4'h0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            coils_q <= coils_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath logic; stop overrides everything while busy.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        index_d = index_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        coils_d = coils_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    base_d  = base_addr;
                    len_d   = length;
                    loop_d  = loop;
                    index_d = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                addr_d  = base_q;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                lat_d   = 2'(READ_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    coils_d = avm_readdata[3:0];
                    step_d  = 1'b1;
                    cnt_d   = (dwell == 16'd0) ? 16'd0 : dwell - 1'b1;
                    state_d = S_DWELL;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_DWELL: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!last_word) begin
                    index_d = index_inc[ADDR_W-1:0];
                    addr_d  = base_q + index_inc[ADDR_W-1:0];
                    state_d = S_FETCH;
                end else if (loop_q) begin
                    index_d = '0;
                    addr_d  = base_q;
                    state_d = S_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            coils_d = coils_q;
            step_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign coils          = coils_q;
    assign step_pulse     = step_q;
    assign avm_address    = addr_q;
    assign avm_read       = (state_q == S_FETCH);
    assign avm_chipselect = (state_q == S_FETCH);
    assign avm_byteenable = 4'hF;
    assign avm_write      = 1'b0;
    assign avm_clken      = 1'b1;

endmodule
